// File: rtl/gpu_alu_pkg.sv
// Shared constants for the GPU ALU issue path: ALU opcodes, widths and issue FSM encoding.
package gpu_alu_pkg;

  localparam int unsigned CTRL_WIDTH = 2;
  localparam int unsigned DATA_WIDTH = 16;

  localparam logic [CTRL_WIDTH-1:0] ALU_ADD = 2'd0;
  localparam logic [CTRL_WIDTH-1:0] ALU_SUB = 2'd1;
  localparam logic [CTRL_WIDTH-1:0] ALU_SL  = 2'd2;
  localparam logic [CTRL_WIDTH-1:0] ALU_SR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/gpu_cmd_fifo.sv
// Synchronous command FIFO; flags derive from the registered occupancy count (no bypass).
module gpu_cmd_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wdata,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rdata     = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gpu_alu_issue.sv
// Issues buffered ALU commands onto registered operand/control lines and returns the
// captured result with its tag over a valid/ready response channel.
module gpu_alu_issue #(
  parameter int unsigned DATA_WIDTH = gpu_alu_pkg::DATA_WIDTH,
  parameter int unsigned CTRL_WIDTH = gpu_alu_pkg::CTRL_WIDTH,
  parameter int unsigned TAG_WIDTH  = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [CTRL_WIDTH-1:0] cmd_op,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic [DATA_WIDTH-1:0] alu_inA,
  output logic [DATA_WIDTH-1:0] alu_inB,
  output logic [CTRL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0] alu_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [TAG_WIDTH-1:0]  rsp_tag,
  output logic                  busy
);
  import gpu_alu_pkg::*;

  localparam int unsigned ENTRY_W = 2 * DATA_WIDTH + CTRL_WIDTH + TAG_WIDTH;
  localparam int unsigned CNT_W   = $clog2(FIFO_DEPTH) + 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [CTRL_WIDTH-1:0] r_alu_ctrl;
  logic [TAG_WIDTH-1:0]  r_tag;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [TAG_WIDTH-1:0]  r_rsp_tag;
  logic                  r_busy;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_W-1:0]      w_count;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic                  w_busy_nxt;
  logic [ENTRY_W-1:0]    w_wdata;
  logic [ENTRY_W-1:0]    w_rdata;
  logic [DATA_WIDTH-1:0] w_h_a;
  logic [DATA_WIDTH-1:0] w_h_b;
  logic [CTRL_WIDTH-1:0] w_h_op;
  logic [TAG_WIDTH-1:0]  w_h_tag;

  assign cmd_ready = !w_full;
  assign w_push    = cmd_valid && !w_full;
  assign w_wdata   = {cmd_a, cmd_b, cmd_op, cmd_tag};
  assign {w_h_a, w_h_b, w_h_op, w_h_tag} = w_rdata;

  gpu_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_wdata),
    .pop   (w_pop),
    .rdata (w_rdata),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Next state and pop decision; a pop only ever happens on entry to DRIVE.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_DRIVE;
        end
      end
      ST_DRIVE: w_state_nxt = ST_RESP;
      ST_RESP: begin
        if (rsp_ready) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = ST_DRIVE;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // busy is registered, so it looks ahead at next-cycle occupancy and state.
  always_comb begin
    w_cnt_nxt  = w_count + CNT_W'(w_push) - CNT_W'(w_pop);
    w_busy_nxt = (w_cnt_nxt != '0) || (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_ctrl  <= CTRL_WIDTH'(ALU_ADD);
      r_tag       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_tag   <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      if (w_pop) begin
        r_alu_a    <= w_h_a;
        r_alu_b    <= w_h_b;
        r_alu_ctrl <= w_h_op;
        r_tag      <= w_h_tag;
      end
      if (r_state == ST_DRIVE) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= alu_out;
        r_rsp_tag   <= r_tag;
      end else if ((r_state == ST_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign alu_inA   = r_alu_a;
  assign alu_inB   = r_alu_b;
  assign alu_ctrl  = r_alu_ctrl;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_tag   = r_rsp_tag;
  assign busy      = r_busy;

endmodule

// File: tb/tb_gpu_alu_issue.sv
// Directed bench for gpu_alu_issue with a behavioural combinational ALU attached.
module tb_gpu_alu_issue;
  import gpu_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;
  logic [1:0]  cmd_op = '0;
  logic [3:0]  cmd_tag = '0;
  logic [15:0] alu_inA;
  logic [15:0] alu_inB;
  logic [1:0]  alu_ctrl;
  logic [15:0] alu_out;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [3:0]  rsp_tag;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] bp_a   [6] = '{16'h1234, 16'h0010, 16'h00FF, 16'hF000, 16'hFFFF, 16'h0005};
  logic [15:0] bp_b   [6] = '{16'h1111, 16'h0020, 16'h0008, 16'h0014, 16'h0002, 16'h0001};
  logic [1:0]  bp_op  [6] = '{ALU_ADD, ALU_SUB, ALU_SL, ALU_SR, ALU_ADD, ALU_SUB};
  logic [3:0]  bp_tag [6] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10};

  gpu_alu_issue #(
    .DATA_WIDTH (16),
    .CTRL_WIDTH (2),
    .TAG_WIDTH  (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_op    (cmd_op),
    .cmd_tag   (cmd_tag),
    .alu_inA   (alu_inA),
    .alu_inB   (alu_inB),
    .alu_ctrl  (alu_ctrl),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_tag   (rsp_tag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctrl)
      ALU_ADD: alu_out = alu_inA + alu_inB;
      ALU_SUB: alu_out = alu_inA - alu_inB;
      ALU_SL:  alu_out = alu_inA << alu_inB;
      default: alu_out = alu_inA >> alu_inB;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_cmd(input logic v, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] op, input logic [3:0] tag);
    cmd_valid = v;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    cmd_tag   = tag;
  endtask

  // Waits (bounded) for a response with rsp_ready high, checks it, then lets it handshake.
  task automatic wait_rsp(input string name, input logic [15:0] d, input logic [3:0] t);
    int i = 0;
    while (!rsp_valid && i < 8) begin
      step();
      i++;
    end
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_data"}, 32'(rsp_data), 32'(d));
    chk({name, "_tag"}, 32'(rsp_tag), 32'(t));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic acc;

    // Reset
    rst_n = 1'b0;
    step();
    step();
    chk("rst_alu_inA", 32'(alu_inA), 32'd0);
    chk("rst_alu_inB", 32'(alu_inB), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    rst_n = 1'b1;
    step();

    // Single ADD with 2-cycle latency
    rsp_ready = 1'b1;
    drive_cmd(1'b1, 16'h0003, 16'h0004, ALU_ADD, 4'd1);
    step();
    drive_cmd(1'b0, 16'h0, 16'h0, ALU_ADD, 4'd0);
    chk("add_busy_after_accept", 32'(busy), 32'd1);
    chk("add_no_rsp_n1", 32'(rsp_valid), 32'd0);
    step();
    chk("add_drive_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
    chk("add_drive_inA", 32'(alu_inA), 32'h0003);
    chk("add_drive_inB", 32'(alu_inB), 32'h0004);
    chk("add_no_rsp_n2", 32'(rsp_valid), 32'd0);
    step();
    chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("add_rsp_data", 32'(rsp_data), 32'h0007);
    chk("add_rsp_tag", 32'(rsp_tag), 32'd1);
    step();
    chk("add_rsp_done", 32'(rsp_valid), 32'd0);
    chk("add_idle_busy", 32'(busy), 32'd0);

    // SUB wrap and shifts back-to-back
    drive_cmd(1'b1, 16'h0000, 16'h0001, ALU_SUB, 4'd2);
    step();
    drive_cmd(1'b1, 16'h0001, 16'h0004, ALU_SL, 4'd3);
    step();
    drive_cmd(1'b1, 16'h8000, 16'h000F, ALU_SR, 4'd4);
    step();
    drive_cmd(1'b0, 16'h0, 16'h0, ALU_ADD, 4'd0);
    chk("b2b_r0_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_r0_data", 32'(rsp_data), 32'hFFFF);
    chk("b2b_r0_tag", 32'(rsp_tag), 32'd2);
    step();
    chk("b2b_gap0", 32'(rsp_valid), 32'd0);
    step();
    chk("b2b_r1_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_r1_data", 32'(rsp_data), 32'h0010);
    chk("b2b_r1_tag", 32'(rsp_tag), 32'd3);
    step();
    chk("b2b_gap1", 32'(rsp_valid), 32'd0);
    step();
    chk("b2b_r2_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_r2_data", 32'(rsp_data), 32'h0001);
    chk("b2b_r2_tag", 32'(rsp_tag), 32'd4);
    step();
    chk("b2b_end_valid", 32'(rsp_valid), 32'd0);
    chk("b2b_end_busy", 32'(busy), 32'd0);

    // Backpressure fill: offer 6, expect 5 accepted
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      if (k < 6) drive_cmd(1'b1, bp_a[k], bp_b[k], bp_op[k], bp_tag[k]);
      else       drive_cmd(1'b0, 16'h0, 16'h0, ALU_ADD, 4'd0);
      acc = cmd_ready && (k < 6);
      step();
      if (acc) k++;
    end
    chk("bp_accepted", 32'(k), 32'd5);
    chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    chk("bp_fifo_count", 32'(dut.w_count), 32'd4);
    chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
    chk("bp_hold_data0", 32'(rsp_data), 32'h2345);
    chk("bp_hold_tag0", 32'(rsp_tag), 32'd5);
    step();
    step();
    step();
    chk("bp_hold_data1", 32'(rsp_data), 32'h2345);
    chk("bp_hold_tag1", 32'(rsp_tag), 32'd5);
    chk("bp_still_full", 32'(cmd_ready), 32'd0);
    drive_cmd(1'b0, 16'h0, 16'h0, ALU_ADD, 4'd0);
    rsp_ready = 1'b1;
    wait_rsp("bp_r0", 16'h2345, 4'd5);
    wait_rsp("bp_r1", 16'hFFF0, 4'd6);
    wait_rsp("bp_r2", 16'hFF00, 4'd7);
    wait_rsp("bp_r3_bigshift", 16'h0000, 4'd8);
    wait_rsp("bp_r4_wrap", 16'h0001, 4'd9);
    step();
    step();
    chk("bp_no_extra_rsp", 32'(rsp_valid), 32'd0);
    chk("bp_drained_busy", 32'(busy), 32'd0);

    // Push and pop on the same edge at count 2
    rsp_ready = 1'b0;
    drive_cmd(1'b1, 16'h0001, 16'h0001, ALU_ADD, 4'd1);
    step();
    drive_cmd(1'b1, 16'h0100, 16'h0001, ALU_SUB, 4'd2);
    step();
    drive_cmd(1'b1, 16'h0001, 16'h000F, ALU_SL, 4'd3);
    step();
    chk("pp_count_before", 32'(dut.w_count), 32'd2);
    chk("pp_r0_valid", 32'(rsp_valid), 32'd1);
    chk("pp_r0_data", 32'(rsp_data), 32'h0002);
    drive_cmd(1'b1, 16'hABCD, 16'h0004, ALU_SR, 4'd4);
    rsp_ready = 1'b1;
    step();
    drive_cmd(1'b0, 16'h0, 16'h0, ALU_ADD, 4'd0);
    chk("pp_count_after", 32'(dut.w_count), 32'd2);
    chk("pp_popped_inA", 32'(alu_inA), 32'h0100);
    chk("pp_popped_ctrl", 32'(alu_ctrl), 32'(ALU_SUB));
    chk("pp_valid_dropped", 32'(rsp_valid), 32'd0);
    wait_rsp("pp_r1", 16'h00FF, 4'd2);
    wait_rsp("pp_r2", 16'h8000, 4'd3);
    wait_rsp("pp_r3", 16'h0ABC, 4'd4);
    chk("pp_end_busy", 32'(busy), 32'd0);

    // Reset in DRIVE with three commands queued
    rsp_ready = 1'b0;
    drive_cmd(1'b1, 16'h000A, 16'h0005, ALU_ADD, 4'd1);
    step();
    drive_cmd(1'b1, 16'h0111, 16'h0222, ALU_ADD, 4'd2);
    step();
    drive_cmd(1'b1, 16'h0009, 16'h0003, ALU_SUB, 4'd3);
    step();
    drive_cmd(1'b1, 16'h0001, 16'h0001, ALU_SL, 4'd4);
    step();
    drive_cmd(1'b1, 16'h0010, 16'h0001, ALU_SR, 4'd5);
    rsp_ready = 1'b1;
    step();
    drive_cmd(1'b0, 16'h0, 16'h0, ALU_ADD, 4'd0);
    chk("mr_pre_count", 32'(dut.w_count), 32'd3);
    chk("mr_pre_inA", 32'(alu_inA), 32'h0111);
    chk("mr_pre_rsp_data", 32'(rsp_data), 32'h000F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_alu_inA", 32'(alu_inA), 32'd0);
    chk("mr_alu_inB", 32'(alu_inB), 32'd0);
    chk("mr_alu_ctrl", 32'(alu_ctrl), 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rsp_data", 32'(rsp_data), 32'd0);
    chk("mr_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_cmd_ready", 32'(cmd_ready), 32'd1);
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("mr_no_rsp_after_release", 32'(rsp_valid), 32'd0);
    end
    chk("mr_final_busy", 32'(busy), 32'd0);
    chk("mr_final_cmd_ready", 32'(cmd_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpu_alu_issue.md
Name: gpu_alu_issue

Overview:
Command-side driver for the GPU's combinational 2-operand ALU (add/sub/shift-left/shift-right). It accepts tagged ALU commands over a valid/ready interface and buffers them in a small FIFO. It issues each command to the ALU by driving registered operand and control lines, captures the ALU result one cycle later, and returns it with its tag over a valid/ready response interface. It sits between the GPU command decoder and the ALU, so the ALU needs no handshake of its own.

Parameters:
DATA_WIDTH, 16, operand/result width; matches the ALU in/out width.
CTRL_WIDTH, 2, ALU control width.
TAG_WIDTH, 4, opaque command tag returned with the result.
FIFO_DEPTH, 4, command FIFO entries; power of 2, at least 2.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
cmd_valid  in  1  command present.
cmd_ready  out  1  FIFO can accept; equals !fifo_full (registered count, no same-cycle pop credit).
cmd_a  in  DATA_WIDTH  operand A.
cmd_b  in  DATA_WIDTH  operand B (shift amount for SL/SR).
cmd_op  in  CTRL_WIDTH  ALU op: ADD=0, SUB=1, SL=2, SR=3.
cmd_tag  in  TAG_WIDTH  command tag.
alu_inA  out  DATA_WIDTH  registered operand A to the ALU.
alu_inB  out  DATA_WIDTH  registered operand B to the ALU.
alu_ctrl  out  CTRL_WIDTH  registered ALU control.
alu_out  in  DATA_WIDTH  ALU combinational result.
rsp_valid  out  1  result available.
rsp_ready  in  1  consumer accepts result.
rsp_data  out  DATA_WIDTH  captured result.
rsp_tag  out  TAG_WIDTH  tag of the result.
busy  out  1  FIFO not empty, or state is not IDLE.

Behaviour:
- Reset (async assert, sync-free release): FIFO empty, state IDLE. All outputs are 0: alu_inA, alu_inB, alu_ctrl (=ADD), rsp_valid, rsp_data, rsp_tag, busy. cmd_ready reads 1 after reset.
- Push: cmd_valid && cmd_ready at a rising edge writes {a,b,op,tag} to the FIFO tail.
- Full FIFO: cmd_ready=0, even if a pop happens in the same cycle.
- Pop and push in the same cycle on a non-full FIFO: both happen, count unchanged.
- Empty FIFO: no bypass. A command pushed at edge N can be popped at edge N+1 at the earliest.
- FSM states: IDLE, DRIVE, RESP.
  - IDLE: if the FIFO is non-empty, pop the head, load alu_inA/alu_inB/alu_ctrl and the tag register, go to DRIVE.
  - DRIVE: one cycle; the ALU settles combinationally. At the next edge capture alu_out into rsp_data, set rsp_valid=1, go to RESP.
  - RESP: hold rsp_valid, rsp_data and rsp_tag stable until rsp_valid && rsp_ready.
    - On handshake with FIFO non-empty: pop the next command, load the ALU registers, go to DRIVE, rsp_valid=0.
    - On handshake with FIFO empty: go to IDLE, rsp_valid=0.
- Latency: accept at edge N -> DRIVE at N+1 -> rsp_valid high after edge N+2 (2 cycles). Sustained throughput is 1 result per 2 cycles with rsp_ready held high.
- ALU outputs hold their last values in IDLE and RESP; they change only on a pop.
- Arithmetic is performed by the ALU; the block passes results through unmodified.
  - Results wrap modulo 2^DATA_WIDTH.
  - Shift amounts of DATA_WIDTH or more yield 0, per ALU semantics.
- Responses return strictly in command order; tags are not checked.
- Reset mid-operation: the in-flight command, FIFO contents and pending response are all discarded.
- busy goes low only when the FIFO is empty and the state is IDLE.

Decomposition:
- Shared package gpu_alu_pkg holds:
  - ALU op constants ALU_ADD=0, ALU_SUB=1, ALU_SL=2, ALU_SR=3.
  - CTRL_WIDTH and the default DATA_WIDTH.
  - The FSM state encoding (IDLE, DRIVE, RESP).
- One sub-module, gpu_cmd_fifo: synchronous FIFO with width 2*DATA_WIDTH+CTRL_WIDTH+TAG_WIDTH, depth FIFO_DEPTH, and ports push/pop/full/empty/count. It shares clk and rst_n.
- The FSM and ALU-side registers live in gpu_alu_issue.

Test Plan:
- Single ADD: a=0x0003, b=0x0004, tag=1, rsp_ready=1 -> alu_ctrl=0 during DRIVE; rsp_valid asserted 2 cycles after accept, rsp_data=0x0007, rsp_tag=1; then busy=0.
- SUB wrap and shifts, back-to-back: 0x0000-0x0001, then 0x0001 SL 4, then 0x8000 SR 15 -> responses in order are 0xFFFF, 0x0010, 0x0001, spaced 2 cycles apart.
- Backpressure fill: rsp_ready=0, offer 6 commands ->
  - 5 accepted (1 in RESP, 4 in FIFO), then cmd_ready=0.
  - rsp_data/rsp_tag stay stable while stalled.
  - Releasing rsp_ready drains all 5 in order.
- Push/pop same cycle: FIFO at count 2, push during the RESP->DRIVE pop edge -> count stays 2 and no command is lost or duplicated.
- Reset mid-operation: assert rst_n=0 while in DRIVE with 3 queued -> all outputs 0 immediately (async). After release no response appears, cmd_ready=1 and busy=0.
